// File: rtl/req_dispatch.sv
// -----------------------------------------------------------------------------
// req_dispatch
//
// Drains the endpoint requestor-ID FIFO and serves one ID at a time to the
// response/TX engine. Each ID is popped in IDLE, offered on a registered
// valid/ready issue handshake (ISSUE), and then awaited for a completion pulse
// (WAIT) bounded by a TIMEOUT-cycle timer. Failed or timed-out attempts are
// re-issued up to MAX_RETRY times; after that the ID is dropped and reported.
// Only one request is ever outstanding.
//
// Parameters:
//   ID_W      requestor ID width (FIFO entry width)
//   TIMEOUT   WAIT cycles before an attempt is declared failed (>= 2)
//   MAX_RETRY re-issues allowed after the first failed attempt
//
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   enable          permits new pops; only looked at in IDLE
//   fifo_empty      FIFO empty flag
//   fifo_rdata      FIFO head entry (valid while !fifo_empty)
//   fifo_ren        one-cycle pop strobe (combinational, IDLE only)
//   svc_valid       issue request to the response engine
//   svc_id          ID being issued
//   svc_ready       engine accepts the issue
//   svc_done        completion pulse for the outstanding ID
//   svc_err         qualifies svc_done as a failed attempt
//   busy            high whenever not in IDLE
//   drop_pulse      one-cycle pulse when an ID is abandoned
//   drop_id         last abandoned ID, held until the next drop
//
// Optional build macro REQ_DISPATCH_STATS_EN adds:
//   stats_clr       synchronous clear of the statistics counters
//   done_cnt        successful services       (16-bit, saturating)
//   retry_cnt_total re-issues                 (16-bit, saturating)
//   drop_cnt        abandoned IDs             (16-bit, saturating)
// -----------------------------------------------------------------------------
module req_dispatch #(
  parameter int ID_W      = 5,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            enable,
  input  logic            fifo_empty,
  input  logic [ID_W-1:0] fifo_rdata,
  output logic            fifo_ren,
  output logic            svc_valid,
  output logic [ID_W-1:0] svc_id,
  input  logic            svc_ready,
  input  logic            svc_done,
  input  logic            svc_err,
  output logic            busy,
  output logic            drop_pulse,
  output logic [ID_W-1:0] drop_id
`ifdef REQ_DISPATCH_STATS_EN
  ,
  input  logic            stats_clr,
  output logic [15:0]     done_cnt,
  output logic [15:0]     retry_cnt_total,
  output logic [15:0]     drop_cnt
`endif
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RC_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_SAT   = {TMR_W{1'b1}};
  localparam logic [RC_W-1:0]  RC_LIMIT  = RC_W'(MAX_RETRY);
  localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic              svc_valid_q, svc_valid_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [ID_W-1:0]   drop_id_q, drop_id_d;
  logic              pop;

  // An attempt fails on an error completion, or on timer expiry when no
  // completion arrives in the same cycle (a completion always wins).
  logic att_fail;
  logic can_retry;

  assign att_fail  = (state_q == S_WAIT) &&
                     ((svc_done && svc_err) || (!svc_done && (timer_q == TMR_LAST)));
  assign can_retry = (retry_cnt_q < RC_LIMIT);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    timer_d      = timer_q;
    retry_cnt_d  = retry_cnt_q;
    svc_valid_d  = svc_valid_q;
    drop_pulse_d = 1'b0;
    drop_id_d    = drop_id_q;
    pop          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          pop         = 1'b1;
          id_d        = fifo_rdata;
          retry_cnt_d = '0;
          svc_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (svc_ready) begin
          svc_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        // Timer saturates rather than wrapping.
        if (timer_q != TMR_SAT) begin
          timer_d = timer_q + TMR_ONE;
        end
        if (svc_done && !svc_err) begin
          state_d = S_IDLE;
        end else if (att_fail) begin
          if (can_retry) begin
            retry_cnt_d = retry_cnt_q + RC_ONE;
            svc_valid_d = 1'b1;
            state_d     = S_ISSUE;
          end else begin
            drop_pulse_d = 1'b1;
            drop_id_d    = id_q;
            state_d      = S_IDLE;
          end
        end
      end

      default: begin
        svc_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      timer_q      <= '0;
      retry_cnt_q  <= '0;
      svc_valid_q  <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      retry_cnt_q  <= retry_cnt_d;
      svc_valid_q  <= svc_valid_d;
      drop_pulse_q <= drop_pulse_d;
      drop_id_q    <= drop_id_d;
    end
  end

  // The pop strobe is combinational from the IDLE state, so it is gated with
  // the reset to keep every output low while reset is held.
  assign fifo_ren   = pop & n_rst;
  assign svc_valid  = svc_valid_q;
  assign svc_id     = id_q;
  assign busy       = (state_q != S_IDLE);
  assign drop_pulse = drop_pulse_q;
  assign drop_id    = drop_id_q;

`ifdef REQ_DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic        evt_done;
  logic        evt_retry;
  logic        evt_drop;
  logic [15:0] done_cnt_q, done_cnt_d;
  logic [15:0] retry_tot_q, retry_tot_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign evt_done  = (state_q == S_WAIT) && svc_done && !svc_err;
  assign evt_retry = att_fail && can_retry;
  assign evt_drop  = att_fail && !can_retry;

  // A clear in the same cycle as an increment leaves the counter at zero.
  always_comb begin
    done_cnt_d  = done_cnt_q;
    retry_tot_d = retry_tot_q;
    drop_cnt_d  = drop_cnt_q;
    if (stats_clr) begin
      done_cnt_d  = '0;
      retry_tot_d = '0;
      drop_cnt_d  = '0;
    end else begin
      if (evt_done)  done_cnt_d  = sat_inc(done_cnt_q);
      if (evt_retry) retry_tot_d = sat_inc(retry_tot_q);
      if (evt_drop)  drop_cnt_d  = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_cnt_q  <= '0;
      retry_tot_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      done_cnt_q  <= done_cnt_d;
      retry_tot_q <= retry_tot_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign done_cnt        = done_cnt_q;
  assign retry_cnt_total = retry_tot_q;
  assign drop_cnt        = drop_cnt_q;
`endif

endmodule

// File: tb/tb_req_dispatch.sv
// -----------------------------------------------------------------------------
// tb_req_dispatch
//
// Directed bench for req_dispatch (TIMEOUT=8, MAX_RETRY=2). Stimulus pushes
// the expected issued IDs and dropped IDs into queues; a monitor on the
// falling edge pops and compares them whenever the DUT accepts an issue or
// pulses a drop. Cycle-level expectations (busy length, latency, stability)
// are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_req_dispatch;

  localparam int ID_W      = 5;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            enable;
  logic            fifo_empty;
  logic [ID_W-1:0] fifo_rdata;
  logic            fifo_ren;
  logic            svc_valid;
  logic [ID_W-1:0] svc_id;
  logic            svc_ready;
  logic            svc_done;
  logic            svc_err;
  logic            busy;
  logic            drop_pulse;
  logic [ID_W-1:0] drop_id;
`ifdef REQ_DISPATCH_STATS_EN
  logic            stats_clr;
  logic [15:0]     done_cnt;
  logic [15:0]     retry_cnt_total;
  logic [15:0]     drop_cnt;
`endif

  always #5 clk = ~clk;

  req_dispatch #(
    .ID_W      (ID_W),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .svc_valid  (svc_valid),
    .svc_id     (svc_id),
    .svc_ready  (svc_ready),
    .svc_done   (svc_done),
    .svc_err    (svc_err),
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .drop_id    (drop_id)
`ifdef REQ_DISPATCH_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .done_cnt        (done_cnt),
    .retry_cnt_total (retry_cnt_total),
    .drop_cnt        (drop_cnt)
`endif
  );

  // Simple FIFO model: entries written by the stimulus, read pointer advanced
  // by the model one step after a pop strobe is seen.
  logic [ID_W-1:0] fmem [0:15];
  int unsigned     frd = 0;
  int unsigned     fwr = 0;
  logic            pop_now;

  assign fifo_empty = (frd == fwr);
  assign fifo_rdata = fmem[frd[3:0]];

  logic [ID_W-1:0] exp_issue[$];
  logic [ID_W-1:0] exp_drop[$];

  int errors  = 0;
  int checks  = 0;
  int n_pop   = 0;
  int n_issue = 0;
  int n_drop  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ID_W-1:0] id);
    fmem[fwr[3:0]] = id;
    fwr++;
  endtask

  always begin
    @(negedge clk);
    pop_now = fifo_ren;
    @(posedge clk);
    #1;
    if (pop_now) frd++;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (fifo_ren) begin
      n_pop++;
      chk("pop_while_empty", int'(fifo_empty), 0);
    end
    if (svc_valid && svc_ready) begin
      n_issue++;
      if (exp_issue.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: svc_id %0d accepted, none expected", svc_id);
      end else begin
        chk("issue_id", int'(svc_id), int'(exp_issue.pop_front()));
      end
    end
    if (drop_pulse) begin
      n_drop++;
      if (exp_drop.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drop: drop_id %0d pulsed, none expected", drop_id);
      end else begin
        chk("drop_id", int'(drop_id), int'(exp_drop.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int p0;
    int i0;
    int d0;
    int bc;
    int bad;

    n_rst     = 1'b0;
    enable    = 1'b1;
    svc_ready = 1'b0;
    svc_done  = 1'b0;
    svc_err   = 1'b0;
`ifdef REQ_DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    tick();
    tick();

    // Reset state
    chk("rst_fifo_ren",   int'(fifo_ren),   0);
    chk("rst_svc_valid",  int'(svc_valid),  0);
    chk("rst_svc_id",     int'(svc_id),     0);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_drop_pulse", int'(drop_pulse), 0);
    chk("rst_drop_id",    int'(drop_id),    0);
    n_rst = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Single success: accept immediately, complete on second WAIT cycle
    exp_issue.push_back(5'h03);
    p0 = n_pop;
    bc = 0;
    svc_ready = 1'b1;
    push(5'h03);
    for (int i = 1; i <= 6; i++) begin
      tick();
      bc += int'(busy);
      svc_done = (i == 3);
    end
    chk("t1_busy_cycles", bc, 3);
    chk("t1_pops", n_pop - p0, 1);
    chk("t1_idle", int'(busy), 0);
    svc_ready = 1'b0;

    // Back-pressure: svc_ready low for 10 cycles, extra entry queued
    exp_issue.push_back(5'h11);
    p0 = n_pop;
    bad = 0;
    push(5'h11);
    tick();
    push(5'h15);
    for (int i = 0; i < 10; i++) begin
      if (!(svc_valid && (svc_id == 5'h11))) bad++;
      tick();
    end
    chk("t2_issue_stable", bad, 0);
    chk("t2_pops_while_busy", n_pop - p0, 1);
    svc_ready = 1'b1;
    tick();
    chk("t2_wait_busy", int'(busy), 1);
    chk("t2_valid_dropped", int'(svc_valid), 0);
    svc_ready = 1'b0;
    enable    = 1'b0;
    svc_done  = 1'b1;
    tick();
    svc_done = 1'b0;
    chk("t2_done_idle", int'(busy), 0);

    // Disabled with two entries queued: no pops
    push(5'h16);
    p0 = n_pop;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bc += int'(busy);
    end
    chk("t5_disabled_pops", n_pop - p0, 0);
    chk("t5_disabled_busy", bc, 0);

    // Drain both at full rate; svc_done held high is ignored in ISSUE
    exp_issue.push_back(5'h15);
    exp_issue.push_back(5'h16);
    p0 = n_pop;
    svc_ready = 1'b1;
    svc_done  = 1'b1;
    enable    = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("drain_pops", n_pop - p0, 2);
    chk("drain_idle", int'(busy), 0);
    svc_done  = 1'b0;
    svc_ready = 1'b0;

    // Empty FIFO with enable: nothing happens
    p0 = n_pop;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bc += int'(busy);
    end
    chk("t5_empty_pops", n_pop - p0, 0);
    chk("t5_empty_busy", bc, 0);

    // Error on every attempt: three issues, then drop
    exp_issue.push_back(5'h07);
    exp_issue.push_back(5'h07);
    exp_issue.push_back(5'h07);
    exp_drop.push_back(5'h07);
    i0 = n_issue;
    d0 = n_drop;
    svc_ready = 1'b1;
    svc_done  = 1'b1;
    svc_err   = 1'b1;
    push(5'h07);
    for (int i = 1; i <= 7; i++) tick();
    chk("t3_drop_pulse", int'(drop_pulse), 1);
    chk("t3_drop_id", int'(drop_id), 7);
    chk("t3_issue_count", n_issue - i0, 3);
    svc_done  = 1'b0;
    svc_err   = 1'b0;
    svc_ready = 1'b0;
    tick();
    chk("t3_pulse_once", int'(drop_pulse), 0);
    chk("t3_drop_id_held", int'(drop_id), 7);
    chk("t3_drop_count", n_drop - d0, 1);

    // Timeout then re-issue; second attempt completes on the expiry cycle
    exp_issue.push_back(5'h1F);
    exp_issue.push_back(5'h1F);
    i0 = n_issue;
    svc_ready = 1'b1;
    push(5'h1F);
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 9) chk("t4_no_reissue_early", int'(svc_valid), 0);
      if (i == 10) begin
        chk("t4_reissue_after_timeout", int'(svc_valid), 1);
        chk("t4_reissue_id", int'(svc_id), 31);
      end
      svc_done = (i == 18);
    end
    chk("t4_expiry_done_idle", int'(busy), 0);
    chk("t4_no_retry", int'(svc_valid), 0);
    chk("t4_issue_count", n_issue - i0, 2);
    svc_ready = 1'b0;

`ifdef REQ_DISPATCH_STATS_EN
    chk("stats_done", int'(done_cnt), 5);
    chk("stats_retry", int'(retry_cnt_total), 3);
    chk("stats_drop", int'(drop_cnt), 1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr_done", int'(done_cnt), 0);
    chk("stats_clr_retry", int'(retry_cnt_total), 0);
`endif

    // Reset while waiting on 0x0A: silent abandon, then pop on first cycle
    exp_issue.push_back(5'h0A);
    svc_ready = 1'b1;
    push(5'h0A);
    tick();
    tick();
    tick();
    chk("t6_in_wait", int'(busy), 1);
    #2;
    n_rst = 1'b0;
    push(5'h0C);
    #1;
    chk("t6_rst_fifo_ren",   int'(fifo_ren),   0);
    chk("t6_rst_svc_valid",  int'(svc_valid),  0);
    chk("t6_rst_svc_id",     int'(svc_id),     0);
    chk("t6_rst_busy",       int'(busy),       0);
    chk("t6_rst_drop_pulse", int'(drop_pulse), 0);
    chk("t6_rst_drop_id",    int'(drop_id),    0);
    exp_issue.push_back(5'h0C);
    tick();
    tick();
    p0 = n_pop;
    n_rst = 1'b1;
    tick();
    chk("t6_first_pop", n_pop - p0, 1);
    chk("t6_issue_valid", int'(svc_valid), 1);
    chk("t6_issue_id", int'(svc_id), 12);
    tick();
    svc_done = 1'b1;
    tick();
    svc_done  = 1'b0;
    svc_ready = 1'b0;
    chk("t6_final_idle", int'(busy), 0);
`ifdef REQ_DISPATCH_STATS_EN
    chk("stats_after_reset_done", int'(done_cnt), 1);
`endif

    tick();
    tick();
    chk("issue_queue_drained", exp_issue.size(), 0);
    chk("drop_queue_drained", exp_drop.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_dispatch.md
Name: req_dispatch

Overview:
Dispatch controller that drains the endpoint requestor-ID FIFO and hands one ID at a time to the response/TX engine. It uses a valid/ready issue handshake and waits for completion, bounded by a timeout. Failed or timed-out services are retried up to a limit, then dropped. The block sits between the requestor FIFO's pop side and the response engine, and serializes service so only one request is outstanding at a time.

Parameters:
ID_W, 5, requestor ID width (matches FIFO entry width)
TIMEOUT, 1024, cycles in WAIT before a service attempt is declared failed (>=2)
MAX_RETRY, 2, re-issues allowed after the first attempt fails (0 = no retry)

Ports:
clk  in  1  clock
n_rst  in  1  async active-low reset
enable  in  1  allow new pops from FIFO; sampled in IDLE only
fifo_empty  in  1  FIFO empty flag
fifo_rdata  in  ID_W  FIFO head entry, valid combinationally while !fifo_empty
fifo_ren  out  1  one-cycle pop strobe
svc_valid  out  1  issue request to response engine
svc_id  out  ID_W  requestor ID being issued
svc_ready  in  1  engine accepts issue
svc_done  in  1  one-cycle completion pulse for outstanding ID
svc_err  in  1  qualifies svc_done: attempt failed
busy  out  1  high in any state other than IDLE
drop_pulse  out  1  one-cycle pulse when an ID is abandoned
drop_id  out  ID_W  ID abandoned, held until next drop

Behaviour:
- Reset: clk is the clock; n_rst is asynchronous and active-low. All outputs are 0 and the state is IDLE. id_q, the timer and retry_cnt are 0. Reset mid-operation abandons the outstanding ID silently, with no drop_pulse.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If enable && !fifo_empty: fifo_ren=1 for exactly this cycle, id_q<=fifo_rdata, retry_cnt<=0, next state ISSUE.
  - Otherwise fifo_ren=0 and the block stays in IDLE.
  - fifo_ren is never asserted outside IDLE. fifo_ren is never asserted while fifo_empty=1.
- ISSUE:
  - svc_valid=1 and svc_id=id_q are registered and stable until accepted.
  - On svc_ready: next state WAIT and timer<=0. svc_valid drops the cycle after acceptance.
  - Latency from the pop cycle to svc_valid high is 1 cycle.
- WAIT:
  - The timer increments each cycle; it is width clog2(TIMEOUT+1) and does not wrap.
  - svc_done && !svc_err: success, next state IDLE.
  - svc_done && svc_err, or timer==TIMEOUT-1 with no svc_done: the attempt fails.
    - If retry_cnt<MAX_RETRY: retry_cnt++ and next state ISSUE with the same id_q.
    - Otherwise: drop_pulse=1 for one cycle, drop_id<=id_q, next state IDLE.
  - svc_done in the same cycle as timeout expiry: svc_done wins and is evaluated normally.
- Ignored inputs:
  - svc_done outside WAIT is ignored.
  - svc_ready outside ISSUE is ignored.
- enable deassert mid-operation: the current ID runs to completion or drop, and no further pops occur.
- Throughput:
  - Back-to-back FIFO entries give at best one pop per 3 cycles (IDLE→ISSUE→WAIT→IDLE), assuming svc_ready and svc_done are immediate.
  - IDLE is always visited between IDs, so each new pop re-samples enable and fifo_empty.

Optional Feature:
REQ_DISPATCH_STATS_EN
- Defined: adds three 16-bit saturating output ports.
  - done_cnt: +1 per success.
  - retry_cnt_total: +1 per re-issue.
  - drop_cnt: +1 per drop.
  - All counters saturate at 0xFFFF, reset to 0, and clear synchronously on a new input stats_clr. If stats_clr and an increment occur in the same cycle, the counter reads 0.
- Undefined: these ports and stats_clr are absent. Core behaviour is identical either way.

Test Plan:
- FIFO holds 0x03, enable=1, svc_ready=1 immediately, svc_done one cycle later with svc_err=0:
  - Required: fifo_ren pulses once, svc_id=0x03, busy=1 for 3 cycles, then IDLE.
  - With STATS_EN: done_cnt=1.
- ID 0x11, svc_ready held low 10 cycles:
  - Required: svc_valid and svc_id=0x11 stable all 10 cycles; no second fifo_ren; WAIT entered the cycle after svc_ready.
- ID 0x07, MAX_RETRY=2, svc_done with svc_err=1 on every attempt:
  - Required: exactly 3 issues of 0x07, then drop_pulse with drop_id=0x07.
  - With STATS_EN: retry_cnt_total=2, drop_cnt=1.
- ID 0x1F, TIMEOUT=8, no svc_done:
  - Required: the attempt fails 8 cycles after acceptance and 0x1F is re-issued.
  - Repeat with svc_done asserted on the expiry cycle: success, with no retry and no drop.
- fifo_empty=1, enable=1 for 20 cycles:
  - Required: fifo_ren stays 0 and busy stays 0.
  - Then enable=0 with 2 entries queued: no pops.
- Reset asserted while in WAIT with ID 0x0A:
  - Required: state IDLE and all outputs 0 asynchronously, with no drop_pulse.
  - After release with the FIFO non-empty: the next pop occurs on the first enabled cycle.
